// File: rtl/bin_act_packer.sv
// Accumulates popcount beats per neuron, thresholds each sum into one activation
// bit and packs the bits LSB-first into IN_WIDTH-bit words. Define BINACT_SAT_EN for a saturating accumulator plus a sticky acc_ovf flag.
module bin_act_packer #(
  parameter int IN_WIDTH     = 32,
  parameter int OUTPUT_WIDTH = 16,
  parameter int ACC_WIDTH    = 24,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [CNT_WIDTH-1:0]       cfg_chunks,
  input  logic [ACC_WIDTH-1:0]       cfg_threshold,
  input  logic                       pc_valid,
  output logic                       pc_ready,
  input  logic [OUTPUT_WIDTH-1:0]    pc_data,
  input  logic                       flush,
  output logic                       pk_valid,
  input  logic                       pk_ready,
  output logic [IN_WIDTH-1:0]        pk_data,
  output logic [$clog2(IN_WIDTH):0]  pk_bits
`ifdef BINACT_SAT_EN
  ,
  output logic                       acc_ovf
`endif
);

  localparam int IW = $clog2(IN_WIDTH);
  localparam int BW = IW + 1;

  logic [ACC_WIDTH-1:0]    acc_q, acc_d;
  logic [ACC_WIDTH-1:0]    thr_lat_q, thr_lat_d;
  logic [CNT_WIDTH-1:0]    chunk_cnt_q, chunk_cnt_d;
  logic [CNT_WIDTH-1:0]    chunks_lat_q, chunks_lat_d;
  logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [IN_WIDTH-1:0]     pack_q, pack_d;
  logic                    flush_pend_q, flush_pend_d;
  logic                    pk_valid_q, pk_valid_d;
  logic [IN_WIDTH-1:0]     pk_data_q, pk_data_d;
  logic [BW-1:0]           pk_bits_q, pk_bits_d;

  logic                    beat;
  logic                    last_beat;
  logic                    bit_val;
  logic [CNT_WIDTH-1:0]    chunks_eff;
  logic [ACC_WIDTH-1:0]    thr_eff;
  logic [ACC_WIDTH-1:0]    pc_ext;
  logic [ACC_WIDTH-1:0]    sum;
  logic [IN_WIDTH-1:0]     pack_fill;
  logic                    word_done;

  // Handshake: a transfer happens on any edge where valid & ready are both high.
  // pc_ready drops only while the output register holds an unaccepted word;
  // pk_valid/pk_data/pk_bits hold steady until pk_ready is seen high.
  assign pc_ready = ~(pk_valid_q & ~pk_ready);
  assign beat     = pc_valid & pc_ready;
  assign pk_valid = pk_valid_q;
  assign pk_data  = pk_data_q;
  assign pk_bits  = pk_bits_q;

  always_comb begin
    pc_ext = '0;
    pc_ext[OUTPUT_WIDTH-1:0] = pc_data;
  end

`ifdef BINACT_SAT_EN
  logic [ACC_WIDTH:0] sum_ext;
  logic               acc_ovf_q, acc_ovf_d;
  assign sum_ext = {1'b0, acc_q} + {1'b0, pc_ext};
  assign sum     = sum_ext[ACC_WIDTH] ? '1 : sum_ext[ACC_WIDTH-1:0];
  assign acc_ovf = acc_ovf_q;
  always_comb begin
    acc_ovf_d = acc_ovf_q | (beat & sum_ext[ACC_WIDTH]);
  end
`else
  assign sum = acc_q + pc_ext;
`endif

  // First beat of a neuron uses live cfg; later beats use the latched copy.
  always_comb begin
    chunks_eff = chunks_lat_q;
    thr_eff    = thr_lat_q;
    if (chunk_cnt_q == '0) begin
      chunks_eff = (cfg_chunks == '0) ? CNT_WIDTH'(1) : cfg_chunks;
      thr_eff    = cfg_threshold;
    end
  end

  assign last_beat = (chunk_cnt_q == chunks_eff - CNT_WIDTH'(1));
  assign bit_val   = (sum >= thr_eff);

  always_comb begin
    acc_d        = acc_q;
    thr_lat_d    = thr_lat_q;
    chunk_cnt_d  = chunk_cnt_q;
    chunks_lat_d = chunks_lat_q;
    bit_cnt_d    = bit_cnt_q;
    pack_d       = pack_q;
    pack_fill    = pack_q;
    word_done    = 1'b0;
    flush_pend_d = flush_pend_q | flush;
    pk_valid_d   = pk_valid_q & ~pk_ready;
    pk_data_d    = pk_data_q;
    pk_bits_d    = pk_bits_q;

    pack_fill[bit_cnt_q[IW-1:0]] = bit_val;

    if (beat) begin
      if (chunk_cnt_q == '0) begin
        chunks_lat_d = chunks_eff;
        thr_lat_d    = thr_eff;
      end
      if (last_beat) begin
        acc_d       = '0;
        chunk_cnt_d = '0;
        if (bit_cnt_q == BW'(IN_WIDTH - 1)) begin
          word_done = 1'b1;
          pack_d    = '0;
          bit_cnt_d = '0;
        end else begin
          pack_d    = pack_fill;
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end else begin
        acc_d       = sum;
        chunk_cnt_d = chunk_cnt_q + CNT_WIDTH'(1);
      end
    end

    if (word_done) begin
      pk_valid_d = 1'b1;
      pk_data_d  = pack_fill;
      pk_bits_d  = BW'(IN_WIDTH);
    end

    // Flush waits for a neuron boundary and a free (or draining) output slot.
    if (flush_pend_d && (chunk_cnt_d == '0) && pc_ready) begin
      flush_pend_d = 1'b0;
      if (bit_cnt_d != '0) begin
        pk_valid_d = 1'b1;
        pk_data_d  = pack_d;
        pk_bits_d  = bit_cnt_d;
        pack_d     = '0;
        bit_cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q        <= '0;
      thr_lat_q    <= '0;
      chunk_cnt_q  <= '0;
      chunks_lat_q <= '0;
      bit_cnt_q    <= '0;
      pack_q       <= '0;
      flush_pend_q <= 1'b0;
      pk_valid_q   <= 1'b0;
      pk_data_q    <= '0;
      pk_bits_q    <= '0;
`ifdef BINACT_SAT_EN
      acc_ovf_q    <= 1'b0;
`endif
    end else begin
      acc_q        <= acc_d;
      thr_lat_q    <= thr_lat_d;
      chunk_cnt_q  <= chunk_cnt_d;
      chunks_lat_q <= chunks_lat_d;
      bit_cnt_q    <= bit_cnt_d;
      pack_q       <= pack_d;
      flush_pend_q <= flush_pend_d;
      pk_valid_q   <= pk_valid_d;
      pk_data_q    <= pk_data_d;
      pk_bits_q    <= pk_bits_d;
`ifdef BINACT_SAT_EN
      acc_ovf_q    <= acc_ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_bin_act_packer.sv
// Directed bench for bin_act_packer: expected words are queued when the
// stimulus is driven and popped as the packer hands each word downstream.
module tb_bin_act_packer;
  localparam int IN_WIDTH     = 32;
  localparam int OUTPUT_WIDTH = 16;
  localparam int ACC_WIDTH    = 17;
  localparam int CNT_WIDTH    = 8;
  localparam int BW           = $clog2(IN_WIDTH) + 1;
  localparam int W            = BW + IN_WIDTH;

  logic                    clk;
  logic                    rst_n;
  logic [CNT_WIDTH-1:0]    cfg_chunks;
  logic [ACC_WIDTH-1:0]    cfg_threshold;
  logic                    pc_valid;
  logic                    pc_ready;
  logic [OUTPUT_WIDTH-1:0] pc_data;
  logic                    flush;
  logic                    pk_valid;
  logic                    pk_ready;
  logic [IN_WIDTH-1:0]     pk_data;
  logic [BW-1:0]           pk_bits;
`ifdef BINACT_SAT_EN
  logic                    acc_ovf;
`endif

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  int n_checks = 0;
  int n_err    = 0;

  bin_act_packer #(
    .IN_WIDTH(IN_WIDTH), .OUTPUT_WIDTH(OUTPUT_WIDTH),
    .ACC_WIDTH(ACC_WIDTH), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_chunks(cfg_chunks), .cfg_threshold(cfg_threshold),
    .pc_valid(pc_valid), .pc_ready(pc_ready), .pc_data(pc_data), .flush(flush),
    .pk_valid(pk_valid), .pk_ready(pk_ready), .pk_data(pk_data), .pk_bits(pk_bits)
`ifdef BINACT_SAT_EN
    , .acc_ovf(acc_ovf)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every downstream transfer must match the head of exp_q
  always @(negedge clk) begin
    if (rst_n && pk_valid && pk_ready) begin
      chk("word_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("pk_data", pk_data, mon_e[IN_WIDTH-1:0]);
        chk("pk_bits", pk_bits, mon_e[W-1:IN_WIDTH]);
      end
    end
  end

  // driver tasks (all return at posedge + 1)
  task automatic push_exp(input int bits, input logic [IN_WIDTH-1:0] data);
    exp_q.push_back({BW'(bits), data});
  endtask

  task automatic send_beat(input logic [OUTPUT_WIDTH-1:0] d);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    pc_valid = 1'b1;
    pc_data  = d;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = pc_ready;
      @(posedge clk);
      #1;
      n++;
    end
    pc_valid = 1'b0;
    chk("beat_accepted", acc, 1);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic idle_no_word(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      chk(tag, pk_valid, 0);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  logic [IN_WIDTH-1:0] w_exp, w_exp2;
  int v;

  initial begin
    rst_n = 1'b0; pc_valid = 1'b0; pc_data = '0; flush = 1'b0; pk_ready = 1'b1;
    cfg_chunks = 8'd1; cfg_threshold = 17'd16;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_pk_valid", pk_valid, 0);
    chk("rst_pk_data", pk_data, 0);
    chk("rst_pk_bits", pk_bits, 0);
    chk("rst_pc_ready", pc_ready, 1);
`ifdef BINACT_SAT_EN
    chk("rst_acc_ovf", acc_ovf, 0);
`endif

    // full word, alternating 20/10 against threshold 16
    push_exp(32, 32'h5555_5555);
    for (int i = 0; i < 32; i++) begin
      send_beat((i % 2 == 0) ? 16'd20 : 16'd10);
      if (i == 30) chk("full_not_early", pk_valid, 0);
    end
    chk("full_latency", pk_valid, 1);
    drain();

    // partial word via flush, 3 chunks per neuron
    cfg_chunks = 8'd3; cfg_threshold = 17'd48;
    send_beat(16); send_beat(16); send_beat(15);
    send_beat(16); send_beat(16); send_beat(16);
    chk("partial_no_word", pk_valid, 0);
    push_exp(2, 32'h0000_0002);
    pulse_flush();
    drain();
    pulse_flush();
    idle_no_word("empty_flush", 4);

    // backpressure: hold first word 5 cycles, then a second random word
    cfg_chunks = 8'd1; cfg_threshold = 17'd16;
    pk_ready = 1'b0;
    w_exp = '0;
    for (int i = 0; i < 32; i++) begin
      v = $urandom_range(0, 40);
      if (v >= 16) w_exp[i] = 1'b1;
      send_beat(OUTPUT_WIDTH'(v));
    end
    push_exp(32, w_exp);
    pc_valid = 1'b1; pc_data = 16'd30;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_pc_ready", pc_ready, 0);
      chk("bp_pk_valid", pk_valid, 1);
      chk("bp_pk_data", pk_data, w_exp);
      chk("bp_pk_bits", pk_bits, 32);
      @(posedge clk);
      #1;
    end
    pk_ready = 1'b1;
    w_exp2 = 32'h1;
    send_beat(16'd30);
    for (int i = 1; i < 32; i++) begin
      v = $urandom_range(0, 40);
      if (v >= 16) w_exp2[i] = 1'b1;
      send_beat(OUTPUT_WIDTH'(v));
    end
    push_exp(32, w_exp2);
    drain();

    // deferred flush; cfg changes mid-neuron must be ignored
    cfg_chunks = 8'd4; cfg_threshold = 17'd10;
    send_beat(3);
    cfg_threshold = 17'd1000;
    send_beat(3);
    cfg_chunks = 8'd1;
    pulse_flush();
    chk("defer_no_word_a", pk_valid, 0);
    send_beat(3);
    chk("defer_no_word_b", pk_valid, 0);
    push_exp(1, 32'h0000_0001);
    send_beat(3);
    chk("defer_emitted", pk_valid, 1);
    drain();

    // flush coinciding with the beat that completes a word
    cfg_chunks = 8'd1; cfg_threshold = 17'd5;
    w_exp = '0;
    for (int i = 0; i < 32; i++) if (i % 3 == 0) w_exp[i] = 1'b1;
    push_exp(32, w_exp);
    for (int i = 0; i < 31; i++) send_beat((i % 3 == 0) ? 16'd9 : 16'd2);
    flush = 1'b1;
    send_beat(16'd2);
    flush = 1'b0;
    drain();
    idle_no_word("fill_flush_extra", 3);

    // reset mid-word discards the 7 collected bits
    cfg_threshold = 17'd16;
    for (int i = 0; i < 7; i++) send_beat(16'd20);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst2_pk_valid", pk_valid, 0);
    chk("rst2_pk_bits", pk_bits, 0);
`ifdef BINACT_SAT_EN
    chk("rst2_acc_ovf", acc_ovf, 0);
`endif
    cfg_threshold = 17'd1;
    push_exp(32, 32'h0);
    for (int i = 0; i < 32; i++) send_beat(16'd0);
    drain();

    // accumulator overflow: 3 x 0xFFFF into 17 bits
    cfg_chunks = 8'd3; cfg_threshold = 17'h1FFFF;
`ifdef BINACT_SAT_EN
    push_exp(1, 32'h1);
`else
    push_exp(1, 32'h0);
`endif
    send_beat(16'hFFFF); send_beat(16'hFFFF); send_beat(16'hFFFF);
    pulse_flush();
    drain();
`ifdef BINACT_SAT_EN
    chk("ovf_sticky", acc_ovf, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/bin_act_packer.md
Name: bin_act_packer

Overview:
- Consumer-side counterpart to the binary MAC: takes the stream of popcount results leaving the XNOR/popcount datapath and turns them into packed binary activations.
- Accumulates cfg_chunks popcount beats per neuron and thresholds the sum into one activation bit.
- Packs activation bits LSB-first into IN_WIDTH-bit words for the next layer's binary MAC inputs.
- Valid/ready handshake on both sides.

Parameters:
- IN_WIDTH, 32, width of the packed output word (matches the binary MAC operand width).
- OUTPUT_WIDTH, 16, width of an incoming popcount beat.
- ACC_WIDTH, 24, accumulator width; must be greater than or equal to OUTPUT_WIDTH.
- CNT_WIDTH, 8, width of cfg_chunks.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- cfg_chunks  in  CNT_WIDTH  popcount beats per neuron; 0 is treated as 1.
- cfg_threshold  in  ACC_WIDTH  activation bit = (sum >= threshold), unsigned.
- pc_valid  in  1  popcount beat valid.
- pc_ready  out  1  popcount beat accepted when pc_valid & pc_ready.
- pc_data  in  OUTPUT_WIDTH  popcount value.
- flush  in  1  single-cycle request to emit a partially filled word.
- pk_valid  out  1  packed word valid.
- pk_ready  in  1  downstream accepts word.
- pk_data  out  IN_WIDTH  packed activations; bit i = i-th neuron of the word.
- pk_bits  out  clog2(IN_WIDTH)+1  count of valid bits in pk_data (1..IN_WIDTH).
- acc_ovf  out  1  sticky accumulator overflow; present only with BINACT_SAT_EN.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - Clears acc, chunk_cnt, bit_cnt, pack register, flush_pend and the output register.
  - Outputs: pk_valid=0, pk_data=0, pk_bits=0, acc_ovf=0.
  - A reset mid-neuron or mid-word discards all partial data; no word is emitted.
- pc_ready = ~(pk_valid & ~pk_ready). This is combinational: input stalls only while the output register holds an unaccepted word.
- Neuron sampling: when chunk_cnt==0, the accepted beat latches cfg_chunks (0 becomes 1) and cfg_threshold into internal registers. These are held until the neuron completes, so cfg changes mid-neuron have no effect.
- Per accepted beat:
  - sum = acc + zero-extended pc_data (ACC_WIDTH arithmetic).
  - If chunk_cnt == chunks_lat-1: neuron completes. bit = (sum >= thr_lat). bit is written at pack[bit_cnt], bit_cnt increments, acc clears and chunk_cnt clears.
  - Otherwise: acc = sum and chunk_cnt increments.
- Word completion: when bit_cnt reaches IN_WIDTH, in the same edge:
  - The pack register moves to the output register with pk_bits=IN_WIDTH and pk_valid=1.
  - pack and bit_cnt clear.
  - Latency: pk_valid is high in the cycle after the edge that accepts the completing beat.
- Output register:
  - pk_data and pk_bits are stable while pk_valid & ~pk_ready.
  - pk_valid clears on the edge where pk_ready=1, unless a new word loads on that same edge; in that case pk_valid stays 1 with the new data, giving back-to-back throughput.
- Flush:
  - flush sets flush_pend (sticky).
  - flush_pend is serviced on the first edge where chunk_cnt==0 after any beat processing on that edge, and the output register is free or draining (pk_ready=1).
  - Service with bit_cnt>0: emits pack with unused upper bits 0 and pk_bits=bit_cnt.
  - Service with bit_cnt==0: emits nothing.
  - flush_pend clears on service.
- Flush mid-neuron: deferred until that neuron's last beat is accepted. The emitted word then includes that neuron's bit.
- Flush on the same edge as a beat that fills the word: the full word is emitted; flush then finds bit_cnt==0 and emits nothing.
- Flush while the output register is blocked: stays pending, and beats may still not be accepted (pc_ready=0).

Optional Feature:
- BINACT_SAT_EN defined:
  - Accumulator add saturates at 2^ACC_WIDTH-1.
  - Any saturating add sets acc_ovf. acc_ovf is sticky until reset.
- BINACT_SAT_EN undefined:
  - Add wraps modulo 2^ACC_WIDTH.
  - The acc_ovf port does not exist.

Test Plan:
- Full word: cfg_chunks=1, threshold=16, 32 beats alternating 20,10 with pk_ready=1 -> one word pk_data=0x55555555, pk_bits=32, pk_valid one cycle after the 32nd accept.
- Partial word via flush: cfg_chunks=3, threshold=48, beats 16,16,15 then 16,16,16, then flush -> pk_data=0x00000002, pk_bits=2; a second flush emits nothing.
- Backpressure: after a full word, hold pk_ready=0 for 5 cycles -> pc_ready=0, and pk_data/pk_bits stable for all 5 cycles. Release pk_ready -> next 32 neurons produce the second word with no lost or duplicated bits.
- Deferred flush and cfg sampling: cfg_chunks=4, flush pulsed after beat 2, and cfg_threshold changed 10->1000 after beat 1 -> word emitted only after beat 4 with pk_bits=1, and bit evaluated against 10.
- Reset mid-word: 7 neurons accepted, rst_n=0 for 1 cycle, then 32 neurons of value 0 with threshold 1 -> pk_valid=0 and acc_ovf=0 after reset, then a single word 0x00000000 with pk_bits=32.
- Overflow (ACC_WIDTH=17, cfg_chunks=3, threshold=0x1FFFF, three beats of 0xFFFF):
  - With BINACT_SAT_EN: sum saturates to 0x1FFFF, bit=1, acc_ovf=1.
  - Without BINACT_SAT_EN: sum wraps to 0x0FFFD, bit=0.
